flush_ctrl: RTL and testbench
=============================

Name: flush_ctrl

Overview:
- Sequences pipeline flush and fetch redirection after WB-stage commit events: exception, ertn, and TLB-instruction refetch.
- Sits between the WB stage and CSR file on one side and the IF stage / instruction-SRAM-like bus on the other.
- Tracks outstanding instruction requests, discards stale responses after a flush, then issues a single held redirect to IF.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered instruction requests.
- CNT_W, 3, outstanding counter width; must hold 0..MAX_OUTSTANDING.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous active-low.
- wb_ex  in  1  WB exception commit, already qualified by ws_valid.
- wb_tlbr  in  1  committing exception is TLB refill; valid only with wb_ex.
- ertn_flush  in  1  ertn commit, already qualified.
- wb_refetch_flush  in  1  TLB-instruction refetch commit, already qualified.
- wb_pc  in  32  PC of the committing instruction.
- csr_eentry  in  32  exception entry.
- csr_tlbrentry  in  32  TLB refill entry.
- csr_era  in  32  return address.
- inst_req_hs  in  1  instruction request accepted this cycle (req & addr_ok).
- inst_data_ok  in  1  instruction response returned this cycle.
- flush  out  1  one-cycle pulse; all stages invalidate.
- inst_req_allow  out  1  IF may issue a new request.
- inst_resp_discard  out  1  this cycle's response is stale; IF must drop it.
- redirect_valid  out  1  redirect target is valid.
- redirect_pc  out  32  redirect target.
- redirect_ready  in  1  IF accepts the redirect.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, outstanding cnt=0, target=0.
  - All outputs 0, except inst_req_allow=1 (cnt<MAX).
- Event decode, combinational, priority wb_ex > ertn_flush > wb_refetch_flush. `event` = OR of the three.
- Target select, latched on the event cycle:
  - wb_ex & wb_tlbr -> csr_tlbrentry
  - wb_ex -> csr_eentry
  - ertn_flush -> csr_era
  - wb_refetch_flush -> wb_pc+4 (32-bit wrap)
- flush = event, combinational, same cycle. It is not gated by state.
- Outstanding counter (all states):
  - cnt_next = cnt + inst_req_hs - inst_data_ok.
  - hs and data_ok together -> unchanged.
  - data_ok with cnt=0 -> cnt stays 0; flag as assertion error in simulation.
  - hs with cnt=MAX cannot occur because inst_req_allow=0; assert in simulation.
- inst_req_allow = (state==IDLE) & ~event & (cnt < MAX_OUTSTANDING).
- States: IDLE, DRAIN, REDIRECT.
  - Any state + event -> latch target. Go to DRAIN if cnt_next != 0, else REDIRECT. A later event always overrides the earlier target.
  - DRAIN: inst_resp_discard = inst_data_ok. When cnt_next == 0 and no event -> REDIRECT.
  - REDIRECT: redirect_valid=1, redirect_pc=target, held stable until redirect_ready. On the redirect_valid & redirect_ready cycle -> IDLE, with inst_req_allow=1 from the next cycle.
  - IDLE: inst_resp_discard=0 (live responses pass through).
- Latency:
  - Event with cnt=0 -> redirect_valid on the next cycle.
  - Event with cnt=N -> redirect_valid the cycle after the Nth data_ok.
- Responses arriving on the event cycle itself are stale and discarded; inst_resp_discard = inst_data_ok when event=1.
- Reset mid-DRAIN or mid-REDIRECT -> immediate IDLE, cnt=0. The bus is reset at the same time.

Decomposition:
- Shared package/header constants:
  - state encoding FC_IDLE=2'd0, FC_DRAIN=2'd1, FC_REDIRECT=2'd2
  - event priority indices
- Target selection uses existing ECODE/EARRAY definitions only via wb_tlbr; no new codes.
- One natural sub-module: outstanding_cnt (up/down saturating counter with underflow/overflow assertions), reusable for the data-side bus later.

Test Plan:
- Idle exception: cnt=0, pulse wb_ex, csr_eentry=0x1C008000 -> flush=1 same cycle; redirect_valid=1, redirect_pc=0x1C008000 next cycle; redirect_ready=1 -> IDLE, inst_req_allow=1 following cycle.
- Drain then TLB refill: three requests accepted (cnt=3); wb_ex & wb_tlbr, csr_tlbrentry=0x1C00F000 -> inst_req_allow=0; each of 3 data_ok has inst_resp_discard=1; redirect_valid the cycle after the third, pc=0x1C00F000.
- Refetch wrap: wb_refetch_flush, wb_pc=0xFFFFFFFC -> redirect_pc=0x00000000.
- Priority: wb_ex and ertn_flush together, eentry=0x100, era=0x200 -> redirect_pc=0x100.
- Override: during DRAIN (cnt=2) ertn_flush with era=0x1C000040 -> second flush pulse, target replaced, redirect_pc=0x1C000040 after both responses.
- Saturation/reset: four handshakes -> cnt=4, inst_req_allow=0; simultaneous hs+data_ok at cnt=3 keeps cnt=3; resetn low in REDIRECT -> redirect_valid=0 immediately, busy=0.

Source files
------------

// File: rtl/flush_ctrl_pkg.sv
// Shared definitions for the commit-event flush/redirect controller:
// state encoding, event priority indices and redirect target selection.
package flush_ctrl_pkg;

   typedef enum logic [1:0] {
      FC_IDLE     = 2'd0,
      FC_DRAIN    = 2'd1,
      FC_REDIRECT = 2'd2
   } fc_state_e;

   // Bit positions in the event vector; lower index wins.
   localparam int FC_EV_EX      = 0;
   localparam int FC_EV_ERTN    = 1;
   localparam int FC_EV_REFETCH = 2;
   localparam int FC_EV_NUM     = 3;

   function automatic logic [31:0] fc_target(
      input logic [FC_EV_NUM-1:0] ev,
      input logic                 tlbr,
      input logic [31:0]          pc,
      input logic [31:0]          eentry,
      input logic [31:0]          tlbrentry,
      input logic [31:0]          era
   );
      logic [31:0] tgt;
      if (ev[FC_EV_EX]) begin
         tgt = tlbr ? tlbrentry : eentry;
      end else if (ev[FC_EV_ERTN]) begin
         tgt = era;
      end else begin
         tgt = pc + 32'd4;
      end
      return tgt;
   endfunction

endpackage

// File: rtl/flush_ctrl_outstanding_cnt.sv
// Up/down counter of accepted-but-unanswered bus requests, saturating at
// both ends, with simulation checks for underflow and overflow.
module flush_ctrl_outstanding_cnt #(
   parameter int MAX = 4,
   parameter int W   = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic [W-1:0] cnt_next_o
);

   localparam logic [W-1:0] MAX_C = W'(MAX);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i && cnt_q < MAX_C) begin
         cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign cnt_next_o = cnt_d;

   a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(dec_i && !inc_i && cnt_q == '0))
      else $error("outstanding_cnt: response with nothing outstanding");

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(inc_i && !dec_i && cnt_q == MAX_C))
      else $error("outstanding_cnt: request accepted while saturated");

endmodule

// File: rtl/flush_ctrl.sv
// Flushes the pipeline on WB commit events, drains stale instruction
// responses, then presents one held redirect to the fetch stage.
module flush_ctrl
   import flush_ctrl_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wb_ex,
   input  logic             wb_tlbr,
   input  logic             ertn_flush,
   input  logic             wb_refetch_flush,
   input  logic [31:0]      wb_pc,
   input  logic [31:0]      csr_eentry,
   input  logic [31:0]      csr_tlbrentry,
   input  logic [31:0]      csr_era,
   input  logic             inst_req_hs,
   input  logic             inst_data_ok,
   output logic             flush,
   output logic             inst_req_allow,
   output logic             inst_resp_discard,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   input  logic             redirect_ready,
   output logic             busy,
   output fc_state_e        dbg_state_o,
   output logic [CNT_W-1:0] dbg_cnt_o
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

   fc_state_e              state_q;
   logic [31:0]            target_q;
   logic [31:0]            target_d;
   logic [FC_EV_NUM-1:0]   ev_vec;
   logic                   ev_any;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_next;

   always_comb begin
      ev_vec                = '0;
      ev_vec[FC_EV_EX]      = wb_ex;
      ev_vec[FC_EV_ERTN]    = ertn_flush;
      ev_vec[FC_EV_REFETCH] = wb_refetch_flush;
   end

   assign ev_any   = |ev_vec;
   assign target_d = fc_target(ev_vec, wb_tlbr, wb_pc, csr_eentry,
                               csr_tlbrentry, csr_era);

   flush_ctrl_outstanding_cnt #(
      .MAX (MAX_OUTSTANDING),
      .W   (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst_n      (resetn),
      .inc_i      (inst_req_hs),
      .dec_i      (inst_data_ok),
      .cnt_o      (cnt),
      .cnt_next_o (cnt_next)
   );

   // A new event always restarts the sequence and replaces the target.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= FC_IDLE;
         target_q <= '0;
      end else if (ev_any) begin
         target_q <= target_d;
         state_q  <= (cnt_next != '0) ? FC_DRAIN : FC_REDIRECT;
      end else begin
         case (state_q)
            FC_DRAIN:    if (cnt_next == '0) state_q <= FC_REDIRECT;
            FC_REDIRECT: if (redirect_ready) state_q <= FC_IDLE;
            default:     state_q <= state_q;
         endcase
      end
   end

   assign flush             = ev_any;
   assign inst_req_allow    = (state_q == FC_IDLE) && !ev_any && (cnt < MAX_C);
   // Responses on the event cycle belong to the flushed path as well.
   assign inst_resp_discard = inst_data_ok && (ev_any || state_q == FC_DRAIN);
   assign redirect_valid    = (state_q == FC_REDIRECT);
   assign redirect_pc       = target_q;
   assign busy              = (state_q != FC_IDLE);
   assign dbg_state_o       = state_q;
   assign dbg_cnt_o         = cnt;

endmodule

// File: tb/tb_flush_ctrl.sv
// Directed vector bench for flush_ctrl: one table row per clock cycle,
// plus hand-written reset sequences.
module tb_flush_ctrl;
   import flush_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        wb_ex = 1'b0, wb_tlbr = 1'b0, ertn_flush = 1'b0, wb_refetch_flush = 1'b0;
   logic [31:0] wb_pc = '0, csr_eentry = '0, csr_tlbrentry = '0, csr_era = '0;
   logic        inst_req_hs = 1'b0, inst_data_ok = 1'b0, redirect_ready = 1'b0;
   logic        flush, inst_req_allow, inst_resp_discard, redirect_valid, busy;
   logic [31:0] redirect_pc;
   fc_state_e   dbg_state;
   logic [2:0]  dbg_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   flush_ctrl #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .wb_ex             (wb_ex),
      .wb_tlbr           (wb_tlbr),
      .ertn_flush        (ertn_flush),
      .wb_refetch_flush  (wb_refetch_flush),
      .wb_pc             (wb_pc),
      .csr_eentry        (csr_eentry),
      .csr_tlbrentry     (csr_tlbrentry),
      .csr_era           (csr_era),
      .inst_req_hs       (inst_req_hs),
      .inst_data_ok      (inst_data_ok),
      .flush             (flush),
      .inst_req_allow    (inst_req_allow),
      .inst_resp_discard (inst_resp_discard),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .redirect_ready    (redirect_ready),
      .busy              (busy),
      .dbg_state_o       (dbg_state),
      .dbg_cnt_o         (dbg_cnt)
   );

   always #5 clk = ~clk;

   // ev bits: [3] wb_ex, [2] wb_tlbr, [1] ertn_flush, [0] wb_refetch_flush
   // exp_o bits: {flush, inst_req_allow, inst_resp_discard, redirect_valid, busy}
   typedef struct {
      logic [3:0]  ev;
      logic        hs, dok, rdy;
      logic [31:0] pc, ee, era;
      logic [4:0]  exp_o;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[$];

   localparam logic [3:0]  NONE = 4'b0000, EX = 4'b1000, EXT = 4'b1100;
   localparam logic [3:0]  ERT = 4'b0010, REF = 4'b0001, EXER = 4'b1010;
   localparam logic [4:0]  O_IDLE = 5'b01000, O_BLK = 5'b00000, O_EV = 5'b10000;
   localparam logic [4:0]  O_RV = 5'b00011, O_DR = 5'b00001, O_DRD = 5'b00101;
   localparam logic [31:0] E = 32'h1C00_8000, T = 32'h1C00_F000, A = 32'h1C00_0040;

   task automatic add(input logic [3:0] ev, input logic hs, input logic dok,
                      input logic rdy, input logic [31:0] pc, input logic [31:0] ee,
                      input logic [31:0] era, input logic [4:0] eo,
                      input logic [31:0] epc);
      vec_t v;
      v.ev = ev; v.hs = hs; v.dok = dok; v.rdy = rdy;
      v.pc = pc; v.ee = ee; v.era = era;
      v.exp_o = eo; v.exp_pc = epc;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [4:0] eo, input logic [31:0] epc);
      check({name, " outs"}, {27'd0, flush, inst_req_allow, inst_resp_discard,
                              redirect_valid, busy}, {27'd0, eo});
      check({name, " pc"}, redirect_pc, epc);
   endtask

   task automatic drive_idle();
      {wb_ex, wb_tlbr, ertn_flush, wb_refetch_flush} = 4'b0000;
      inst_req_hs = 1'b0; inst_data_ok = 1'b0; redirect_ready = 1'b0;
      wb_pc = '0; csr_eentry = E; csr_era = A;
   endtask

   initial begin
      csr_tlbrentry = T;
      drive_idle();
      repeat (2) @(negedge clk);
      #1;
      check_outs("reset", O_IDLE, 32'h0);
      check("reset state", {30'd0, dbg_state}, {30'd0, FC_IDLE});
      @(negedge clk);
      resetn = 1'b1;

      // idle exception
      add(NONE, 0, 0, 0, 0, E, A, O_IDLE, 0);
      add(EX,   0, 0, 0, 0, E, A, O_EV,   0);
      add(NONE, 0, 0, 0, 0, E, A, O_RV,   E);
      add(NONE, 0, 0, 1, 0, E, A, O_RV,   E);
      add(NONE, 0, 0, 0, 0, E, A, O_IDLE, E);
      // drain then TLB refill
      for (int i = 0; i < 3; i++) add(NONE, 1, 0, 0, 0, E, A, O_IDLE, E);
      add(EXT,  0, 0, 0, 0, E, A, O_EV,   E);
      add(NONE, 0, 1, 0, 0, E, A, O_DRD,  T);
      add(NONE, 0, 0, 0, 0, E, A, O_DR,   T);
      add(NONE, 0, 1, 0, 0, E, A, O_DRD,  T);
      add(NONE, 0, 1, 0, 0, E, A, O_DRD,  T);
      add(NONE, 0, 0, 0, 0, E, A, O_RV,   T);
      add(NONE, 0, 0, 1, 0, E, A, O_RV,   T);
      add(NONE, 0, 0, 0, 0, E, A, O_IDLE, T);
      // refetch with PC wrap
      add(REF,  0, 0, 0, 32'hFFFF_FFFC, E, A, O_EV, T);
      add(NONE, 0, 0, 1, 0, E, A, O_RV, 32'h0);
      // exception beats ertn
      add(EXER, 0, 0, 0, 0, 32'h100, 32'h200, O_EV, 32'h0);
      add(NONE, 0, 0, 1, 0, E, A, O_RV, 32'h100);
      // ertn overrides exception during drain
      add(NONE, 1, 0, 0, 0, E, A, O_IDLE, 32'h100);
      add(NONE, 1, 0, 0, 0, E, A, O_IDLE, 32'h100);
      add(EX,   0, 0, 0, 0, E, A, O_EV, 32'h100);
      add(ERT,  0, 0, 0, 0, E, A, 5'b10001, E);
      add(NONE, 0, 1, 0, 0, E, A, O_DRD, A);
      add(NONE, 0, 1, 0, 0, E, A, O_DRD, A);
      add(NONE, 0, 0, 1, 0, E, A, O_RV, A);
      add(NONE, 0, 0, 0, 0, E, A, O_IDLE, A);
      // response on the event cycle is discarded and counted
      add(NONE, 1, 0, 0, 0, E, A, O_IDLE, A);
      add(EX,   0, 1, 0, 0, E, A, 5'b10100, A);
      add(NONE, 0, 0, 1, 0, E, A, O_RV, E);
      // saturation, live response, simultaneous hs+data_ok
      for (int i = 0; i < 4; i++) add(NONE, 1, 0, 0, 0, E, A, O_IDLE, E);
      add(NONE, 0, 0, 0, 0, E, A, O_BLK, E);
      add(NONE, 0, 1, 0, 0, E, A, O_BLK, E);
      add(NONE, 1, 1, 0, 0, E, A, O_IDLE, E);
      add(NONE, 0, 0, 0, 0, E, A, O_IDLE, E);
      add(NONE, 1, 0, 0, 0, E, A, O_IDLE, E);
      add(NONE, 0, 0, 0, 0, E, A, O_BLK, E);
      add(REF,  0, 0, 0, 32'h1000, E, A, O_EV, E);
      for (int i = 0; i < 4; i++) add(NONE, 0, 1, 0, 0, E, A, O_DRD, 32'h1004);
      add(NONE, 0, 0, 0, 0, E, A, O_RV, 32'h1004);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         {wb_ex, wb_tlbr, ertn_flush, wb_refetch_flush} = vecs[i].ev;
         inst_req_hs = vecs[i].hs; inst_data_ok = vecs[i].dok;
         redirect_ready = vecs[i].rdy; wb_pc = vecs[i].pc;
         csr_eentry = vecs[i].ee; csr_era = vecs[i].era;
         #1;
         check_outs($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_pc);
      end

      // reset while REDIRECT is pending
      @(negedge clk);
      drive_idle();
      resetn = 1'b0;
      #1;
      check_outs("reset in redirect", O_IDLE, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check_outs("after reset", O_IDLE, 32'h0);

      // reset clears a saturated counter
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         inst_req_hs = 1'b1;
      end
      @(negedge clk);
      inst_req_hs = 1'b0;
      #1;
      check_outs("saturated", O_BLK, 32'h0);
      resetn = 1'b0;
      #1;
      check_outs("reset clears cnt", O_IDLE, 32'h0);
      check("reset cnt", {29'd0, dbg_cnt}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
